// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: icache request/response, hazard/branch-resolution inputs
// and the IF/ID latch payload.
//   slave  : fetch_unit view (consumes icache/control, drives request/IF-ID)
//   master : surrounding pipeline/icache view
interface fetch_unit_if;
  logic        ihit;
  logic [31:0] imemload;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        stall;
  logic        halt;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        bt_update;
  logic [31:0] bt_pc;
  logic [31:0] bt_target;
  logic        bt_taken;
  logic [31:0] imemload_in;
  logic [31:0] pcp4_in;
  logic [31:0] inst_pc_if;
  logic [31:0] predicted_pc_in;
  logic        if_id_enable;
  logic        if_id_flush;

  modport slave (
    input  ihit, imemload, stall, halt, redirect, redirect_pc,
           bt_update, bt_pc, bt_target, bt_taken,
    output imemREN, imemaddr, imemload_in, pcp4_in, inst_pc_if,
           predicted_pc_in, if_id_enable, if_id_flush
  );

  modport master (
    output ihit, imemload, stall, halt, redirect, redirect_pc,
           bt_update, bt_pc, bt_target, bt_taken,
    input  imemREN, imemaddr, imemload_in, pcp4_in, inst_pc_if,
           predicted_pc_in, if_id_enable, if_id_flush
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues icache reads, predicts the
// next PC through a direct-mapped BTB with 2-bit counters, and produces the
// IF/ID latch payload, enable and flush.
// Ports:
//   CLK  : clock, rising edge
//   RST  : asynchronous active-high reset
//   bus  : fetch_unit_if.slave (icache, hazard, redirect, BTB training, IF/ID)
module fetch_unit #(
  parameter logic [31:0] PC_INIT     = 32'h0000_0000,
  parameter int unsigned BTB_ENTRIES = 8,
  parameter int unsigned IDX_W       = $clog2(BTB_ENTRIES)
) (
  input  logic           CLK,
  input  logic           RST,
  fetch_unit_if.slave    bus
);

  localparam int unsigned TAG_W = 30 - IDX_W;

  typedef enum logic {FETCH, HALTED} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;

  logic             btb_valid  [BTB_ENTRIES];
  logic [1:0]       btb_cnt    [BTB_ENTRIES];
  logic [TAG_W-1:0] btb_tag    [BTB_ENTRIES];
  logic [31:0]      btb_target [BTB_ENTRIES];

  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic [TAG_W-1:0] rd_tag, wr_tag;
  logic             btb_hit, wr_hit;
  logic [31:0]      pc_plus4, predicted;
  logic             ren, enable;

  // Lookup side (current PC)
  assign rd_idx    = pc_q[IDX_W+1:2];
  assign rd_tag    = pc_q[31:IDX_W+2];
  assign pc_plus4  = pc_q + 32'd4;
  assign btb_hit   = btb_valid[rd_idx] & (btb_tag[rd_idx] == rd_tag) & btb_cnt[rd_idx][1];
  assign predicted = btb_hit ? btb_target[rd_idx] : pc_plus4;

  // Training side (resolved branch PC)
  assign wr_idx = bus.bt_pc[IDX_W+1:2];
  assign wr_tag = bus.bt_pc[31:IDX_W+2];
  assign wr_hit = btb_valid[wr_idx] & (btb_tag[wr_idx] == wr_tag);

  // State and PC register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= FETCH;
      pc_q    <= PC_INIT;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Next state, next PC and fetch controls; reset gates the request off
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ren     = 1'b0;
    enable  = 1'b0;
    case (state_q)
      FETCH: begin
        ren    = ~RST;
        enable = ~RST & bus.ihit & ~bus.stall & ~bus.redirect;
        if (bus.redirect) begin
          pc_d = bus.redirect_pc;
        end else if (!(bus.halt || bus.stall) && bus.ihit) begin
          pc_d = predicted;
        end
        if (bus.halt) begin
          state_d = HALTED;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // BTB training; lookups in the same cycle see the pre-write contents
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      btb_valid  <= '{default: 1'b0};
      btb_cnt    <= '{default: 2'b01};
      btb_tag    <= '{default: '0};
      btb_target <= '{default: '0};
    end else if (bus.bt_update) begin
      if (wr_hit) begin
        if (bus.bt_taken) begin
          if (btb_cnt[wr_idx] != 2'b11) begin
            btb_cnt[wr_idx] <= btb_cnt[wr_idx] + 2'd1;
          end
          btb_target[wr_idx] <= bus.bt_target;
        end else if (btb_cnt[wr_idx] != 2'b00) begin
          btb_cnt[wr_idx] <= btb_cnt[wr_idx] - 2'd1;
        end
      end else if (bus.bt_taken) begin
        btb_valid[wr_idx]  <= 1'b1;
        btb_tag[wr_idx]    <= wr_tag;
        btb_target[wr_idx] <= bus.bt_target;
        btb_cnt[wr_idx]    <= 2'b10;
      end
    end
  end

  assign bus.imemREN         = ren;
  assign bus.imemaddr        = pc_q;
  assign bus.inst_pc_if      = pc_q;
  assign bus.pcp4_in         = pc_plus4;
  assign bus.imemload_in     = bus.imemload;
  assign bus.predicted_pc_in = predicted;
  assign bus.if_id_enable    = enable;
  assign bus.if_id_flush     = bus.redirect | RST;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: the driver applies stimulus, steps a
// behavioural model and queues the expected outputs; a monitor compares
// them against the DUT once per cycle on the falling edge.
module tb_fetch_unit;
  localparam logic [31:0] PC_INIT = 32'h0000_0000;
  localparam int N = 8;
  localparam int TAG_SHIFT = $clog2(N) + 2;

  typedef struct packed {
    logic        rst;
    logic        ihit;
    logic [31:0] imemload;
    logic        stall;
    logic        halt;
    logic        redirect;
    logic [31:0] rpc;
    logic        upd;
    logic [31:0] bpc;
    logic [31:0] btgt;
    logic        btaken;
  } stim_t;

  typedef struct packed {
    logic        ren;
    logic [31:0] addr;
    logic [31:0] load_in;
    logic [31:0] pcp4;
    logic [31:0] inst_pc;
    logic [31:0] pred;
    logic        en;
    logic        flush;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  fetch_unit_if bus();

  fetch_unit #(.PC_INIT(PC_INIT), .BTB_ENTRIES(N)) dut (
    .CLK(clk), .RST(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  // Reference model: plain PC, a halted flag and per-slot branch records
  logic [31:0] m_pc;
  bit          m_halted;
  bit          m_valid [N];
  int          m_cnt   [N];
  logic [31:0] m_tag   [N];
  logic [31:0] m_tgt   [N];
  stim_t       cur;

  function automatic int slot(input logic [31:0] p);
    return int'((p >> 2) % 32'(N));
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] p);
    return p >> TAG_SHIFT;
  endfunction

  function automatic logic [31:0] m_predict();
    int i = slot(m_pc);
    if (m_valid[i] && m_tag[i] == tag_of(m_pc) && m_cnt[i] >= 2) return m_tgt[i];
    return m_pc + 32'd4;
  endfunction

  task automatic model_reset();
    m_pc = PC_INIT;
    m_halted = 0;
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 0; m_cnt[i] = 1; m_tag[i] = '0; m_tgt[i] = '0;
    end
  endtask

  // Effect of one rising edge with inputs s held across it
  task automatic model_step(input stim_t s);
    logic [31:0] nxt;
    int i;
    if (s.rst) begin
      model_reset();
      return;
    end
    nxt = m_pc;
    if (!m_halted) begin
      if (s.redirect) nxt = s.rpc;
      else if (!(s.halt || s.stall) && s.ihit) nxt = m_predict();
      if (s.halt) m_halted = 1;
    end
    if (s.upd) begin
      i = slot(s.bpc);
      if (m_valid[i] && m_tag[i] == tag_of(s.bpc)) begin
        if (s.btaken) begin
          m_cnt[i] = (m_cnt[i] == 3) ? 3 : m_cnt[i] + 1;
          m_tgt[i] = s.btgt;
        end else begin
          m_cnt[i] = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
        end
      end else if (s.btaken) begin
        m_valid[i] = 1; m_tag[i] = tag_of(s.bpc); m_tgt[i] = s.btgt; m_cnt[i] = 2;
      end
    end
    m_pc = nxt;
  endtask

  function automatic exp_t expect_now(input stim_t s);
    exp_t e;
    bit live = !s.rst && !m_halted;
    e.ren     = live;
    e.addr    = m_pc;
    e.inst_pc = m_pc;
    e.pcp4    = m_pc + 32'd4;
    e.load_in = s.imemload;
    e.pred    = m_predict();
    e.en      = live && s.ihit && !s.stall && !s.redirect;
    e.flush   = s.redirect || s.rst;
    return e;
  endfunction

  task automatic apply(input stim_t s);
    rst             = s.rst;
    bus.ihit        = s.ihit;
    bus.imemload    = s.imemload;
    bus.stall       = s.stall;
    bus.halt        = s.halt;
    bus.redirect    = s.redirect;
    bus.redirect_pc = s.rpc;
    bus.bt_update   = s.upd;
    bus.bt_pc       = s.bpc;
    bus.bt_target   = s.btgt;
    bus.bt_taken    = s.btaken;
  endtask

  function automatic stim_t idle();
    stim_t s = '0;
    s.imemload = $urandom;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    @(posedge clk); #1;
    model_step(cur);
    apply(s);
    cur = s;
    if (s.rst) model_reset();
    exp_q.push_back(expect_now(s));
  endtask

  // Reset raised between edges while a fetch is being serviced
  task automatic async_reset();
    stim_t s;
    @(posedge clk); #1;
    model_step(cur);
    s = idle(); s.ihit = 1;
    apply(s);
    #2;
    s.rst = 1;
    rst = 1'b1;
    cur = s;
    model_reset();
    exp_q.push_back(expect_now(s));
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic upd(inout stim_t s, input logic [31:0] p, input logic [31:0] t, input logic tk);
    s.upd = 1; s.bpc = p; s.btgt = t; s.btaken = tk;
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp("imemREN",         32'(bus.imemREN),      32'(e.ren));
        cmp("imemaddr",        bus.imemaddr,          e.addr);
        cmp("inst_pc_if",      bus.inst_pc_if,        e.inst_pc);
        cmp("pcp4_in",         bus.pcp4_in,           e.pcp4);
        cmp("imemload_in",     bus.imemload_in,       e.load_in);
        cmp("predicted_pc_in", bus.predicted_pc_in,   e.pred);
        cmp("if_id_enable",    32'(bus.if_id_enable), 32'(e.en));
        cmp("if_id_flush",     32'(bus.if_id_flush),  32'(e.flush));
      end
    end
  end

  initial begin
    stim_t s;
    s = idle(); s.rst = 1;
    apply(s);
    cur = s;
    model_reset();

    drive(s); drive(s);
    s = idle(); s.ihit = 1;
    drive(s); drive(s);                       // pc 0, 4
    s = idle();
    drive(s); drive(s); drive(s);             // waiting at pc 8
    s = idle(); s.ihit = 1;
    drive(s);                                 // 8 -> 12
    upd(s, 32'h10, 32'h40, 1'b1);
    drive(s);                                 // 12 -> 16, train 0x10
    s = idle(); s.ihit = 1;
    drive(s);                                 // 0x10 predicts 0x40
    upd(s, 32'h10, 32'h40, 1'b0);
    drive(s);
    drive(s);                                 // two not-taken -> counter 00
    s = idle(); s.redirect = 1; s.rpc = 32'h10;
    drive(s);
    s = idle(); s.ihit = 1;
    drive(s);                                 // 0x10 now predicts 0x14
    s = idle(); s.ihit = 1; s.stall = 1; s.redirect = 1; s.rpc = 32'h100;
    drive(s);
    s = idle(); s.redirect = 1; s.rpc = 32'h20;
    drive(s);
    s = idle(); s.ihit = 1; s.halt = 1;
    drive(s);                                 // halt at 0x20
    s = idle(); s.ihit = 1; s.redirect = 1; s.rpc = 32'h80;
    drive(s); drive(s);                       // redirect ignored
    @(negedge clk); #1;
    cmp("halted_pc", bus.imemaddr, 32'h20);
    cmp("halted_ren", 32'(bus.imemREN), 32'h0);
    s = idle(); s.rst = 1;
    drive(s);
    s = idle(); s.redirect = 1; s.rpc = 32'hFFFF_FFFC;
    drive(s);
    s = idle(); s.ihit = 1;
    drive(s);                                 // wraps to 0
    drive(s);
    async_reset();
    @(negedge clk); #1;
    cmp("async_rst_pc", bus.imemaddr, PC_INIT);
    s = idle();
    drive(s);

    for (int n = 0; n < 2000; n++) begin
      s = idle();
      s.rst      = ($urandom_range(0, 99) < 2);
      s.ihit     = ($urandom_range(0, 99) < 75);
      s.stall    = ($urandom_range(0, 99) < 12);
      s.halt     = ($urandom_range(0, 99) < 2);
      s.redirect = ($urandom_range(0, 99) < 6);
      s.rpc      = 32'($urandom_range(0, 63)) << 2;
      s.upd      = ($urandom_range(0, 99) < 40);
      s.bpc      = 32'($urandom_range(0, 63)) << 2;
      s.btgt     = 32'($urandom_range(0, 63)) << 2;
      s.btaken   = ($urandom_range(0, 99) < 60);
      drive(s);
    end

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage that produces everything the IF/ID latch consumes: fetched instruction, PC, PC+4 and predicted next PC, plus the latch enable and flush.
- Owns the program counter and drives the instruction-cache request.
- Predicts next PC with a direct-mapped branch target buffer (BTB) holding 2-bit saturating counters.
- Accepts redirects and BTB training from the branch-resolution stage.

Parameters:
PC_INIT, 32'h00000000, PC value loaded on reset
BTB_ENTRIES, 8, number of BTB entries (power of 2, >=2)
IDX_W, $clog2(BTB_ENTRIES), BTB index width; index = pc[IDX_W+1:2], tag = pc[31:IDX_W+2]

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-high
ihit  in  1  icache returns valid imemload this cycle
imemload  in  32  instruction from icache
imemREN  out  1  icache read request
imemaddr  out  32  icache address (= PC)
stall  in  1  hazard unit: hold PC, do not load IF/ID
halt  in  1  committed HALT: stop fetching
redirect  in  1  misprediction resolved; fetch from redirect_pc
redirect_pc  in  32  corrected PC
bt_update  in  1  resolved branch/jump info valid
bt_pc  in  32  PC of resolved branch
bt_target  in  32  resolved target
bt_taken  in  1  branch was taken
imemload_in  out  32  instruction to IF/ID
pcp4_in  out  32  PC+4 to IF/ID
inst_pc_if  out  32  PC of fetched instruction to IF/ID
predicted_pc_in  out  32  predicted next PC to IF/ID
if_id_enable  out  1  IF/ID latch enable
if_id_flush  out  1  IF/ID latch flush

Behaviour:
- Reset: pc=PC_INIT; state=FETCH; all BTB valid=0, counters=2'b01, tags/targets=0.
- While RST is high, imemREN=0, if_id_enable=0, if_id_flush=1. Reset asserted mid-fetch abandons the request; there is no residual state.
- States:
  - FETCH: imemREN=1.
  - HALTED: imemREN=0, if_id_enable=0; terminal until RST; redirect is ignored.
  - FETCH->HALTED on halt=1 at a clock edge; pc is held.
- Combinational outputs:
  - imemaddr=pc; inst_pc_if=pc; pcp4_in=pc+4 (mod 2^32, wraps 32'hFFFFFFFC->0); imemload_in=imemload.
- Prediction:
  - btb_hit = valid[idx] & (tag[idx]==pc tag) & counter[idx][1].
  - predicted_pc_in = btb_hit ? target[idx] : pc+4.
- Enable and flush:
  - if_id_enable = (state==FETCH) & ihit & ~stall & ~redirect.
  - if_id_flush = redirect | RST.
- PC next-state, priority high to low:
  1. RST.
  2. HALTED: hold.
  3. redirect: pc<=redirect_pc. Wins over stall, ihit and halt in the same cycle. State still moves to HALTED if halt=1.
  4. halt or stall: hold.
  5. ihit: pc<=predicted_pc_in.
  6. Otherwise hold; waiting on icache, imemREN stays 1 and the address is stable.
- BTB update on rising edge when bt_update=1, at index/tag from bt_pc:
  - Entry valid and tag matches:
    - Counter saturating: +1 if taken (cap 2'b11), -1 if not (floor 2'b00).
    - target<=bt_target if taken.
  - Miss (invalid or tag mismatch):
    - If taken, allocate: valid=1, tag, target, counter=2'b10.
    - If not taken, no change.
- Simultaneous lookup and update of the same entry: the lookup sees the pre-update contents; the write lands on the edge.
- Update occurs independently of stall/halt/redirect, including in HALTED.
- Latency: instruction reaches IF/ID on the edge where if_id_enable=1. PC advances on that same edge. One instruction per cycle with ihit=1 continuous.

Test Plan:
- Reset then ihit=1 for 4 cycles, empty BTB -> imemaddr 0,4,8,12; if_id_enable=1 each cycle; predicted_pc_in=pc+4.
- ihit=0 for 3 cycles at pc=8 -> imemaddr held at 8, if_id_enable=0, imemREN=1; advances to 12 on first ihit.
- bt_update pc=0x10, target=0x40, taken=1; then fetch 0x10 -> predicted_pc_in=0x40, next imemaddr=0x40. Two not-taken updates -> counter 00, predicted_pc_in=0x14.
- Stall=1 and redirect=1 (redirect_pc=0x100) in the same cycle -> if_id_flush=1, if_id_enable=0, next pc=0x100.
- halt=1 at pc=0x20 -> imemREN=0 from next cycle; pc frozen at 0x20; later redirect ignored; RST returns pc to PC_INIT.
- RST asserted asynchronously mid-cycle with ihit=1 -> outputs immediately take reset values; pc=PC_INIT without waiting for a clock edge.
